// File: rtl/nes_pad_scheduler.sv
// Polls two NES controllers over a shared latch/clock pair, on a free-running
// timer or an external request, and publishes both button bytes atomically.
module nes_pad_scheduler #(
   parameter int POLL_DIV = 225000,
   parameter int HALF     = 162
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_poll_req,
   output logic       o_pad_latch,
   output logic       o_pad_clk,
   input  logic       i_pad_data0,
   input  logic       i_pad_data1,
   output logic [7:0] o_pad0,
   output logic [7:0] o_pad1,
   output logic       o_valid,
   output logic       o_busy
);
   localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(POLL_DIV - 1);
   localparam logic [12:0]   H_LAST = 13'(HALF - 1);
   localparam logic [12:0]   L_LAST = 13'(2 * HALF - 1);

   typedef enum logic [2:0] {IDLE, LATCH, FIRST, CLK_LO, CLK_HI, DONE} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [12:0]   cnt;
   logic [2:0]    bit_idx;
   logic          pending;
   logic          meta0, sync0, meta1, sync1;
   logic [7:0]    shift0, shift1;
   logic          expire, trig;

   // Pad lines are asynchronous to i_clk; idle level is high (released).
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         meta0 <= 1'b1;
         sync0 <= 1'b1;
         meta1 <= 1'b1;
         sync1 <= 1'b1;
      end else begin
         meta0 <= i_pad_data0;
         sync0 <= meta0;
         meta1 <= i_pad_data1;
         sync1 <= meta1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         timer <= '0;
      else if (!i_enable || timer == T_LAST)
         timer <= '0;
      else
         timer <= timer + 1'b1;
   end

   assign expire = i_enable && (timer == T_LAST);
   assign trig   = expire || (i_enable && i_poll_req);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         pending     <= 1'b0;
         shift0      <= '0;
         shift1      <= '0;
         o_pad0      <= '0;
         o_pad1      <= '0;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_pad_latch <= 1'b0;
         o_pad_clk   <= 1'b1;
      end else begin
         o_valid <= 1'b0;
         // One-deep request memory; dropping enable forgets it.
         if (!i_enable)
            pending <= 1'b0;
         else if (trig && state != IDLE)
            pending <= 1'b1;

         case (state)
            IDLE: begin
               if (trig || (pending && i_enable)) begin
                  state       <= LATCH;
                  cnt         <= '0;
                  pending     <= 1'b0;
                  o_pad_latch <= 1'b1;
                  o_busy      <= 1'b1;
               end
            end
            LATCH: begin
               if (cnt == L_LAST) begin
                  state       <= FIRST;
                  cnt         <= '0;
                  o_pad_latch <= 1'b0;
               end else
                  cnt <= cnt + 13'd1;
            end
            FIRST: begin
               if (cnt == H_LAST) begin
                  shift0    <= {~sync0, shift0[7:1]};
                  shift1    <= {~sync1, shift1[7:1]};
                  bit_idx   <= 3'd1;
                  state     <= CLK_LO;
                  cnt       <= '0;
                  o_pad_clk <= 1'b0;
               end else
                  cnt <= cnt + 13'd1;
            end
            CLK_LO: begin
               if (cnt == H_LAST) begin
                  state     <= CLK_HI;
                  cnt       <= '0;
                  o_pad_clk <= 1'b1;
               end else
                  cnt <= cnt + 13'd1;
            end
            CLK_HI: begin
               if (cnt == H_LAST) begin
                  shift0 <= {~sync0, shift0[7:1]};
                  shift1 <= {~sync1, shift1[7:1]};
                  cnt    <= '0;
                  if (bit_idx == 3'd7) begin
                     // Publish with the final bit folded in so o_valid and data align.
                     o_pad0  <= {~sync0, shift0[7:1]};
                     o_pad1  <= {~sync1, shift1[7:1]};
                     o_valid <= 1'b1;
                     state   <= DONE;
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     state     <= CLK_LO;
                     o_pad_clk <= 1'b0;
                  end
               end else
                  cnt <= cnt + 13'd1;
            end
            DONE: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               o_busy      <= 1'b0;
               o_pad_latch <= 1'b0;
               o_pad_clk   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nes_pad_scheduler.sv
// Directed bench for nes_pad_scheduler with a behavioural 4021-style pad model.
module tb_nes_pad_scheduler;
   logic       i_clk;
   logic       i_rst;
   logic       i_enable;
   logic       i_poll_req;
   logic       o_pad_latch;
   logic       o_pad_clk;
   logic       i_pad_data0;
   logic       i_pad_data1;
   logic [7:0] o_pad0;
   logic [7:0] o_pad1;
   logic       o_valid;
   logic       o_busy;

   int total = 0;
   int bad   = 0;

   nes_pad_scheduler #(.POLL_DIV(200), .HALF(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_poll_req(i_poll_req),
      .o_pad_latch(o_pad_latch), .o_pad_clk(o_pad_clk),
      .i_pad_data0(i_pad_data0), .i_pad_data1(i_pad_data1),
      .o_pad0(o_pad0), .o_pad1(o_pad1), .o_valid(o_valid), .o_busy(o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Pad model: load on latch, shift on rising data clock, line low = pressed.
   logic [7:0] btn0 = 8'h00;
   logic [7:0] btn1 = 8'h00;
   logic [7:0] sr0  = 8'hFF;
   logic [7:0] sr1  = 8'hFF;
   always @(posedge o_pad_latch or posedge o_pad_clk) begin
      if (o_pad_latch) begin
         sr0 = ~btn0;
         sr1 = ~btn1;
      end else begin
         sr0 = {1'b1, sr0[7:1]};
         sr1 = {1'b1, sr1[7:1]};
      end
   end
   assign i_pad_data0 = sr0[0];
   assign i_pad_data1 = sr1[0];

   // Event monitor on the falling edge, away from DUT updates.
   int   cyc = 0, lat_rises = 0, lat_hi = 0, clk_falls = 0, clk_lo = 0;
   int   valids = 0, busy_cyc = 0, last_rise = 0, prev_rise = 0, last_valid = 0;
   logic lat_q = 1'b0, clk_q = 1'b1;
   always @(negedge i_clk) begin
      cyc = cyc + 1;
      if (o_pad_latch === 1'b1 && lat_q === 1'b0) begin
         lat_rises = lat_rises + 1;
         prev_rise = last_rise;
         last_rise = cyc;
      end
      if (o_pad_latch === 1'b1) lat_hi = lat_hi + 1;
      if (o_pad_clk === 1'b0 && clk_q === 1'b1) clk_falls = clk_falls + 1;
      if (o_pad_clk === 1'b0) clk_lo = clk_lo + 1;
      if (o_valid === 1'b1) begin
         valids = valids + 1;
         last_valid = cyc;
      end
      if (o_busy === 1'b1) busy_cyc = busy_cyc + 1;
      lat_q = o_pad_latch;
      clk_q = o_pad_clk;
   end

   task automatic tick;
      @(negedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_req;
      i_poll_req = 1'b1;
      tick;
      i_poll_req = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int maxc);
      int n = 0;
      while (o_valid !== 1'b1 && n < maxc) begin
         tick;
         n++;
      end
      chk(tag, 32'(o_valid), 'h1);
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int n = 0;
      while (o_busy !== 1'b0 && n < maxc) begin
         tick;
         n++;
      end
      chk(tag, 32'(o_busy), 'h0);
   endtask

   int b_rise, b_hi, b_fall, b_lo, b_val, b_busy, v1;

   task automatic snap;
      b_rise = lat_rises; b_hi = lat_hi; b_fall = clk_falls;
      b_lo = clk_lo; b_val = valids; b_busy = busy_cyc;
   endtask

   initial begin
      i_rst = 1'b0; i_enable = 1'b0; i_poll_req = 1'b0;
      repeat (3) tick;
      chk("rst_latch", 32'(o_pad_latch), 'h0);
      chk("rst_clk",   32'(o_pad_clk),   'h1);
      chk("rst_busy",  32'(o_busy),      'h0);
      chk("rst_valid", 32'(o_valid),     'h0);
      chk("rst_pad0",  32'(o_pad0),      'h00);
      chk("rst_pad1",  32'(o_pad1),      'h00);
      i_rst = 1'b1;
      tick;

      // Single poll: pad0 A+Start, pad1 Right
      btn0 = 8'h09; btn1 = 8'h80;
      snap;
      i_enable = 1'b1;
      pulse_req;
      wait_valid("single_valid", 200);
      chk("single_pad0_with_valid", 32'(o_pad0), 'h09);
      chk("single_pad1_with_valid", 32'(o_pad1), 'h80);
      wait_idle("single_idle", 50);
      repeat (2) tick;
      i_enable = 1'b0;
      chk("single_lat_rises", 32'(lat_rises - b_rise), 'd1);
      chk("single_lat_hi",    32'(lat_hi - b_hi),      'd8);
      chk("single_clk_falls", 32'(clk_falls - b_fall), 'd7);
      chk("single_clk_lo",    32'(clk_lo - b_lo),      'd28);
      chk("single_valids",    32'(valids - b_val),     'd1);
      chk("single_busy",      32'(busy_cyc - b_busy),  'd69);
      btn0 = 8'hFF; btn1 = 8'hFF;
      repeat (5) tick;
      chk("hold_pad0", 32'(o_pad0), 'h09);

      // Timer-driven polls
      snap;
      i_enable = 1'b1;
      repeat (1000) tick;
      i_enable = 1'b0;
      wait_idle("timer_idle", 200);
      chk("timer_polls",   32'(lat_rises - b_rise), 'd5);
      chk("timer_valids",  32'(valids - b_val),     'd5);
      chk("timer_spacing", 32'(last_rise - prev_rise), 'd200);
      chk("timer_pad0",    32'(o_pad0), 'hFF);

      // Overlapping requests collapse to one extra poll
      btn0 = 8'h22; btn1 = 8'h41;
      snap;
      i_enable = 1'b1;
      pulse_req;
      repeat (10) tick;
      for (int i = 0; i < 3; i++) begin
         pulse_req;
         repeat (4) tick;
      end
      wait_valid("ovl_valid1", 200);
      v1 = last_valid;
      tick;
      wait_valid("ovl_valid2", 200);
      wait_idle("ovl_idle", 50);
      repeat (5) tick;
      i_enable = 1'b0;
      chk("ovl_polls",  32'(lat_rises - b_rise), 'd2);
      chk("ovl_valids", 32'(valids - b_val),     'd2);
      chk("ovl_gap",    32'(last_rise - v1),     'd2);
      chk("ovl_pad1",   32'(o_pad1), 'h41);

      // Request coincident with timer expiry
      tick;
      snap;
      i_enable = 1'b1;
      repeat (199) tick;
      pulse_req;
      wait_valid("sim_valid", 200);
      wait_idle("sim_idle", 50);
      repeat (5) tick;
      i_enable = 1'b0;
      chk("sim_polls",  32'(lat_rises - b_rise), 'd1);
      chk("sim_valids", 32'(valids - b_val),     'd1);

      // Reset during CLK_LO of bit 3
      tick;
      snap;
      i_enable = 1'b1;
      pulse_req;
      begin
         int n = 0;
         while (clk_falls - b_fall < 3 && n < 200) begin
            tick;
            n++;
         end
      end
      chk("rstmid_reached", 32'(clk_falls - b_fall), 'd3);
      i_rst = 1'b0;
      #1;
      chk("rstmid_clk",   32'(o_pad_clk),   'h1);
      chk("rstmid_latch", 32'(o_pad_latch), 'h0);
      chk("rstmid_busy",  32'(o_busy),      'h0);
      chk("rstmid_pad0",  32'(o_pad0),      'h00);
      chk("rstmid_pad1",  32'(o_pad1),      'h00);
      repeat (3) tick;
      chk("rstmid_no_valid", 32'(valids - b_val), 'd0);
      i_rst = 1'b1;
      tick;
      btn0 = 8'h50; btn1 = 8'h03;
      snap;
      pulse_req;
      wait_valid("after_rst_valid", 200);
      chk("after_rst_pad0", 32'(o_pad0), 'h50);
      chk("after_rst_pad1", 32'(o_pad1), 'h03);
      wait_idle("after_rst_idle", 50);
      i_enable = 1'b0;
      chk("after_rst_lat_hi", 32'(lat_hi - b_hi),      'd8);
      chk("after_rst_falls",  32'(clk_falls - b_fall), 'd7);

      // Disable mid-poll with a pending request
      tick;
      btn0 = 8'h81; btn1 = 8'h18;
      snap;
      i_enable = 1'b1;
      pulse_req;
      repeat (5) tick;
      pulse_req;
      repeat (15) tick;
      i_enable = 1'b0;
      wait_valid("dis_valid", 200);
      chk("dis_pad0", 32'(o_pad0), 'h81);
      repeat (150) tick;
      chk("dis_polls",  32'(lat_rises - b_rise), 'd1);
      chk("dis_valids", 32'(valids - b_val),     'd1);
      chk("dis_busy",   32'(o_busy),             'h0);
      chk("dis_timer",  32'(dut.timer),          'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
